// File: rtl/seq_detector_param_pkg.sv
// Shared types and helpers for the programmable serial pattern detector.
package seq_det_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    HUNT = 2'd2
  } state_t;

  // Lengths beyond the supported window saturate to the window size.
  function automatic int clamp_len(input int len, input int max_len);
    return (len > max_len) ? max_len : len;
  endfunction

endpackage

// File: rtl/seq_detector_param_if.sv
// Stream, configuration and status bundle for seq_detector_param.
interface seq_detector_param_if #(
  parameter int MAX_LEN = 8,
  parameter int LEN_W   = 4,
  parameter int CNT_W   = 8
);
  logic               in_valid;
  logic               in_bit;
  logic               cfg_load;
  logic [MAX_LEN-1:0] cfg_pattern;
  logic [LEN_W-1:0]   cfg_len;
  logic               cfg_overlap;
  logic               enable;
  logic               count_clr;
  logic               match;
  logic [CNT_W-1:0]   match_count;
  logic               busy;

  modport master (
    output in_valid, in_bit, cfg_load, cfg_pattern, cfg_len, cfg_overlap, enable, count_clr,
    input  match, match_count, busy
  );

  modport slave (
    input  in_valid, in_bit, cfg_load, cfg_pattern, cfg_len, cfg_overlap, enable, count_clr,
    output match, match_count, busy
  );
endinterface

// File: rtl/seq_detector_param.sv
// Runtime-programmable serial bit-pattern detector with overlap control,
// registered match pulse and saturating match counter.
module seq_detector_param
  import seq_det_pkg::*;
#(
  parameter int MAX_LEN = 8,
  parameter int LEN_W   = 4,
  parameter int CNT_W   = 8
) (
  input logic               clk,
  input logic               reset_n,
  seq_detector_param_if.slave bus
);

  logic [MAX_LEN-1:0] pat_q;
  logic [LEN_W-1:0]   len_q;
  logic               ovl_q;

  state_t             state_q, state_nxt;
  logic [MAX_LEN-1:0] hist_q, hist_nxt, hist_sh, mask;
  logic [LEN_W-1:0]   fill_q, fill_nxt, fill_sh;
  logic               match_q, match_nxt;
  logic [CNT_W-1:0]   cnt_q;
  logic               beat, win_ok, hit;

  assign beat    = bus.in_valid & bus.enable & ~bus.cfg_load;
  assign hist_sh = {hist_q[MAX_LEN-2:0], bus.in_bit};
  assign fill_sh = (fill_q == LEN_W'(MAX_LEN)) ? fill_q : fill_q + LEN_W'(1);

  always_comb begin
    mask = '0;
    for (int i = 0; i < MAX_LEN; i++) mask[i] = (i < int'(len_q));
  end

  // Compare against the window as it will look after this beat's shift.
  assign win_ok = (len_q != '0) && (fill_sh >= len_q);
  assign hit    = win_ok && (((hist_sh ^ pat_q) & mask) == '0);

  always_comb begin
    state_nxt = state_q;
    hist_nxt  = hist_q;
    fill_nxt  = fill_q;
    match_nxt = 1'b0;
    if (!bus.enable) begin
      state_nxt = IDLE;
      hist_nxt  = '0;
      fill_nxt  = '0;
    end else if (bus.cfg_load) begin
      state_nxt = FILL;
      hist_nxt  = '0;
      fill_nxt  = '0;
    end else if (beat) begin
      hist_nxt = hist_sh;
      fill_nxt = fill_sh;
      if (hit) begin
        match_nxt = 1'b1;
        if (ovl_q) begin
          state_nxt = HUNT;
        end else begin
          // Non-overlapping: the matched bits must all be replaced before the next hit.
          state_nxt = FILL;
          fill_nxt  = '0;
        end
      end else begin
        state_nxt = win_ok ? HUNT : FILL;
      end
    end else if (state_q == IDLE) begin
      state_nxt = FILL;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      hist_q  <= '0;
      fill_q  <= '0;
      match_q <= 1'b0;
      cnt_q   <= '0;
      pat_q   <= '0;
      len_q   <= '0;
      ovl_q   <= 1'b1;
    end else begin
      state_q <= state_nxt;
      hist_q  <= hist_nxt;
      fill_q  <= fill_nxt;
      match_q <= match_nxt;
      if (bus.cfg_load) begin
        pat_q <= bus.cfg_pattern;
        len_q <= LEN_W'(clamp_len(int'(bus.cfg_len), MAX_LEN));
        ovl_q <= bus.cfg_overlap;
      end
      if (bus.count_clr)                   cnt_q <= '0;
      else if (match_nxt && cnt_q != '1)   cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign bus.match       = match_q;
  assign bus.match_count = cnt_q;
  assign bus.busy        = (state_q != IDLE);

endmodule
